// File: rtl/scr1_csr_master.sv
// CSR access initiator: sequences Zicsr read/modify/write transfers and the
// machine-mode trap entry sequence onto the CSR register file port.
module scr1_csr_master (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [11:0] csr_num_i,
  input  logic [31:0] rs1_data_i,
  input  logic [4:0]  rs1_idx_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  output logic        exc_ack_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic        csr_except_o,
  input  logic [31:0] csr_rdata_i
);

  // state    | meaning
  // IDLE     | waiting; trap request wins over instruction
  // RD       | read strobe for the instruction CSR
  // RWAIT    | read data returns; old/new computed
  // WR       | write strobe with new value
  // RESP     | response pulse to execute stage
  // X_CAUSE  | write mcause
  // X_EPC    | write mepc
  // X_SRD    | read mstatus
  // X_SWAIT  | mstatus data returns
  // X_SWR    | write updated mstatus
  // X_VRD    | read mtvec
  // X_VWAIT  | mtvec data returns
  // X_DONE   | ack pulse with trap target
  typedef enum logic [3:0] {
    IDLE, RD, RWAIT, WR, RESP,
    X_CAUSE, X_EPC, X_SRD, X_SWAIT, X_SWR, X_VRD, X_VWAIT, X_DONE
  } state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [11:0] csr_num_q;
  logic [31:0] src_q;
  logic        wr_q;
  logic [31:0] old_q;
  logic        cause_irq_q;
  logic [4:0]  cause_lo_q;
  logic [29:0] epc_q;

  logic        req_ready_q, rsp_valid_q, rsp_illegal_q, exc_ack_q;
  logic        csr_we_q, csr_re_q, csr_except_q;
  logic [31:0] rsp_rdata_q, trap_pc_q, csr_addr_q, csr_wdata_q;

  logic [31:0] src_d, new_val_d, mstatus_d, mtvec_base_d, trap_pc_d;
  logic        wr_intent_d, illegal_d;

  // Request decode and data-path values computed from inputs and captured operands.
  always_comb begin
    src_d        = funct3_i[2] ? {27'b0, rs1_idx_i} : rs1_data_i;
    wr_intent_d  = (funct3_i[1:0] == 2'b01) || (rs1_idx_i != 5'd0);
    illegal_d    = (funct3_i[1:0] == 2'b00) ||
                   (wr_intent_d && (csr_num_i[11:10] == 2'b11));
    case (op_q)
      2'b01:   new_val_d = src_q;
      2'b10:   new_val_d = csr_rdata_i | src_q;
      default: new_val_d = csr_rdata_i & ~src_q;
    endcase
    // MPP=11, MPIE takes old MIE, MIE cleared.
    mstatus_d    = {csr_rdata_i[31:13], 2'b11, csr_rdata_i[10:8], csr_rdata_i[3],
                    csr_rdata_i[6:4], 1'b0, csr_rdata_i[2:0]};
    mtvec_base_d = {csr_rdata_i[31:2], 2'b00};
    trap_pc_d    = mtvec_base_d;
    if ((csr_rdata_i[1:0] == 2'b01) && cause_irq_q)
      trap_pc_d = mtvec_base_d + {25'b0, cause_lo_q, 2'b00};
  end

  // Single FSM with registered outputs; strobes and pulses default low each cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      csr_num_q     <= 12'h000;
      src_q         <= 32'h0;
      wr_q          <= 1'b0;
      old_q         <= 32'h0;
      cause_irq_q   <= 1'b0;
      cause_lo_q    <= 5'h0;
      epc_q         <= 30'h0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      exc_ack_q     <= 1'b0;
      trap_pc_q     <= 32'h0;
      csr_we_q      <= 1'b0;
      csr_re_q      <= 1'b0;
      csr_addr_q    <= 32'h0;
      csr_wdata_q   <= 32'h0;
      csr_except_q  <= 1'b0;
    end else begin
      csr_we_q    <= 1'b0;
      csr_re_q    <= 1'b0;
      csr_addr_q  <= 32'h0;
      csr_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      exc_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (exc_req_i) begin
            state_q      <= X_CAUSE;
            req_ready_q  <= 1'b0;
            cause_irq_q  <= exc_cause_i[31];
            cause_lo_q   <= exc_cause_i[4:0];
            epc_q        <= exc_pc_i[31:2];
            csr_except_q <= 1'b1;
            csr_we_q     <= 1'b1;
            csr_addr_q   <= 32'h342;
            csr_wdata_q  <= exc_cause_i;
          end else if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= funct3_i[1:0];
            csr_num_q   <= csr_num_i;
            src_q       <= src_d;
            wr_q        <= wr_intent_d;
            if (illegal_d) begin
              state_q       <= RESP;
              rsp_valid_q   <= 1'b1;
              rsp_illegal_q <= 1'b1;
              rsp_rdata_q   <= 32'h0;
            end else begin
              state_q    <= RD;
              csr_re_q   <= 1'b1;
              csr_addr_q <= {20'h0, csr_num_i};
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        RD: state_q <= RWAIT;
        RWAIT: begin
          old_q <= csr_rdata_i;
          if (wr_q) begin
            state_q     <= WR;
            csr_we_q    <= 1'b1;
            csr_addr_q  <= {20'h0, csr_num_q};
            csr_wdata_q <= new_val_d;
          end else begin
            state_q       <= RESP;
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= 1'b0;
            rsp_rdata_q   <= csr_rdata_i;
          end
        end
        WR: begin
          state_q       <= RESP;
          rsp_valid_q   <= 1'b1;
          rsp_illegal_q <= 1'b0;
          rsp_rdata_q   <= old_q;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= !exc_req_i;
        end
        X_CAUSE: begin
          state_q     <= X_EPC;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= 32'h341;
          csr_wdata_q <= {epc_q, 2'b00};
        end
        X_EPC: begin
          state_q    <= X_SRD;
          csr_re_q   <= 1'b1;
          csr_addr_q <= 32'h300;
        end
        X_SRD: state_q <= X_SWAIT;
        X_SWAIT: begin
          state_q     <= X_SWR;
          csr_we_q    <= 1'b1;
          csr_addr_q  <= 32'h300;
          csr_wdata_q <= mstatus_d;
        end
        X_SWR: begin
          state_q    <= X_VRD;
          csr_re_q   <= 1'b1;
          csr_addr_q <= 32'h305;
        end
        X_VRD: state_q <= X_VWAIT;
        X_VWAIT: begin
          state_q   <= X_DONE;
          exc_ack_q <= 1'b1;
          trap_pc_q <= trap_pc_d;
        end
        X_DONE: begin
          state_q      <= IDLE;
          csr_except_q <= 1'b0;
          req_ready_q  <= !exc_req_i;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_illegal_o = rsp_illegal_q;
  assign exc_ack_o     = exc_ack_q;
  assign trap_pc_o     = trap_pc_q;
  assign csr_addr_o    = csr_addr_q;
  assign csr_wdata_o   = csr_wdata_q;
  assign csr_we_o      = csr_we_q;
  assign csr_re_o      = csr_re_q;
  assign csr_except_o  = csr_except_q;

endmodule
